// File: rtl/bridge_demux2.sv
// bridge_demux2
// Routes one upstream memory request stream to data memory (port A) or the
// device window (port B). Requests are held in a one-entry buffer. A read
// that has been handed downstream blocks new requests until its data comes
// back from the port that took it.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-low reset
//   req_*                 upstream request (valid/ready, we, addr, wdata, be)
//   resp_valid/resp_rdata registered one-cycle read-return pulse
//   a_* / b_*             downstream request per port (valid/ready + fields)
//   a_resp_*/b_resp_*     downstream read return per port (resp_valid, rdata)
module bridge_demux2 #(
    parameter logic [31:0] B_BASE  = 32'h0000_7F00,
    parameter logic [31:0] B_LIMIT = 32'h0000_7F1F
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,

    output logic        resp_valid,
    output logic [31:0] resp_rdata,

    output logic        a_valid,
    input  logic        a_ready,
    output logic        a_we,
    output logic [31:0] a_addr,
    output logic [31:0] a_wdata,
    output logic [3:0]  a_be,
    input  logic        a_resp_valid,
    input  logic [31:0] a_rdata,

    output logic        b_valid,
    input  logic        b_ready,
    output logic        b_we,
    output logic [31:0] b_addr,
    output logic [31:0] b_wdata,
    output logic [3:0]  b_be,
    input  logic        b_resp_valid,
    input  logic [31:0] b_rdata
);

    logic        buf_full;
    logic        buf_we;
    logic        buf_sel;
    logic [31:0] buf_addr;
    logic [31:0] buf_wdata;
    logic [3:0]  buf_be;

    logic        rd_pending;
    logic        rd_sel;

    logic        req_sel;
    logic        accept;
    logic        dn_fire;
    logic        rsp_hit;
    logic [31:0] rsp_data;

    assign req_sel = (req_addr >= B_BASE) && (req_addr <= B_LIMIT);

    // Gated by reset so the upstream sees "not ready" during the reset cycle,
    // independent of whatever the buffer registers hold before that edge.
    assign req_ready = reset & ~buf_full & ~rd_pending;
    assign accept    = req_valid & req_ready;

    assign dn_fire  = buf_full & (buf_sel ? b_ready : a_ready);

    // Only the port that took the outstanding read may complete it; a response
    // in the acceptance cycle is ignored because rd_pending is not yet set.
    assign rsp_hit  = rd_pending & (rd_sel ? b_resp_valid : a_resp_valid);
    assign rsp_data = rd_sel ? b_rdata : a_rdata;

    assign a_valid = buf_full & ~buf_sel;
    assign b_valid = buf_full &  buf_sel;

    assign a_we    = buf_we;
    assign a_addr  = buf_addr;
    assign a_wdata = buf_wdata;
    assign a_be    = buf_be;
    assign b_we    = buf_we;
    assign b_addr  = buf_addr;
    assign b_wdata = buf_wdata;
    assign b_be    = buf_be;

    always_ff @(posedge clk) begin
        if (!reset) begin
            buf_full   <= 1'b0;
            buf_we     <= 1'b0;
            buf_sel    <= 1'b0;
            buf_addr   <= '0;
            buf_wdata  <= '0;
            buf_be     <= '0;
            rd_pending <= 1'b0;
            rd_sel     <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
        end else begin
            // accept needs an empty buffer, so it never coincides with dn_fire
            if (accept) begin
                buf_full  <= 1'b1;
                buf_we    <= req_we;
                buf_sel   <= req_sel;
                buf_addr  <= req_addr;
                buf_wdata <= req_wdata;
                buf_be    <= req_be;
            end else if (dn_fire) begin
                buf_full <= 1'b0;
                if (!buf_we) begin
                    rd_pending <= 1'b1;
                    rd_sel     <= buf_sel;
                end
            end

            // dn_fire needs rd_pending=0, so set and clear never collide
            resp_valid <= rsp_hit;
            if (rsp_hit) begin
                resp_rdata <= rsp_data;
                rd_pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bridge_demux2.sv
module tb_bridge_demux2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        a_valid, a_ready, a_we, a_resp_valid;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic [3:0]  a_be;
    logic        b_valid, b_ready, b_we, b_resp_valid;
    logic [31:0] b_addr, b_wdata, b_rdata;
    logic [3:0]  b_be;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic        sel;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } req_t;

    req_t        exp_q[$];
    logic [31:0] rsp_q[$];

    bridge_demux2 dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_addr(a_addr),
        .a_wdata(a_wdata), .a_be(a_be), .a_resp_valid(a_resp_valid), .a_rdata(a_rdata),
        .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_addr(b_addr),
        .b_wdata(b_wdata), .b_be(b_be), .b_resp_valid(b_resp_valid), .b_rdata(b_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic model_sel(input logic [31:0] a);
        return (a >= 32'h0000_7F00) && (a <= 32'h0000_7F1F);
    endfunction

    function automatic req_t make_req(input logic we, input logic [31:0] addr,
                                      input logic [31:0] wdata, input logic [3:0] be);
        req_t r;
        r.sel = model_sel(addr);
        r.we = we; r.addr = addr; r.wdata = wdata; r.be = be;
        return r;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Drive one request, wait (bounded) for req_ready, return just after the accept edge.
    task automatic accept_req(input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] be);
        int n = 0;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        while (!req_ready && n < 20) begin
            step;
            n++;
        end
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL accept_timeout addr=%h req_ready got %b want 1", addr, req_ready);
        end
        step;
        req_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        step;
        vectors++;
        if ({req_ready, a_valid, b_valid, resp_valid} !== 4'b0000 || resp_rdata !== 32'h0 ||
            {a_we, a_addr, a_wdata, a_be} !== 69'h0 || {b_we, b_addr, b_wdata, b_be} !== 69'h0) begin
            miscompares++;
            $display("FAIL reset_outputs got rdy=%b av=%b bv=%b rv=%b rd=%h aaddr=%h want all 0",
                     req_ready, a_valid, b_valid, resp_valid, resp_rdata, a_addr);
        end
        reset = 1'b1;
        #1;
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release_ready got %b want 1", req_ready);
        end
    endtask

    task automatic test_write_a;
        req_t e;
        int seen = 0;
        a_ready = 1'b1; b_ready = 1'b1;
        exp_q.push_back(make_req(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF));
        accept_req(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
        e = exp_q.pop_front();
        vectors++;
        if ({a_valid, b_valid} !== {~e.sel, e.sel}) begin
            miscompares++;
            $display("FAIL write_a_valid got a=%b b=%b want a=%b b=%b", a_valid, b_valid, ~e.sel, e.sel);
        end
        vectors++;
        if ({a_we, a_addr, a_wdata, a_be} !== {e.we, e.addr, e.wdata, e.be}) begin
            miscompares++;
            $display("FAIL write_a_fields got %b %h %h %h want %b %h %h %h",
                     a_we, a_addr, a_wdata, a_be, e.we, e.addr, e.wdata, e.be);
        end
        for (int i = 0; i < 3; i++) begin
            if (resp_valid === 1'b1 || b_valid === 1'b1) seen++;
            step;
        end
        vectors++;
        if (seen != 0 || a_valid !== 1'b0 || req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL write_a_after got spurious=%0d a_valid=%b ready=%b want 0 0 1",
                     seen, a_valid, req_ready);
        end
    endtask

    task automatic test_addr_sweep;
        logic [31:0] addrs [5];
        req_t e;
        logic [68:0] obs;
        addrs[0] = 32'h0000_7EFF; addrs[1] = 32'h0000_7F00; addrs[2] = 32'h0000_7F1F;
        addrs[3] = 32'h0000_7F20; addrs[4] = 32'hFFFF_FFFC;
        a_ready = 1'b1; b_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(make_req(1'b1, addrs[i], 32'hA5A5_0000 + i, 4'(i + 1)));
            accept_req(1'b1, addrs[i], 32'hA5A5_0000 + i, 4'(i + 1));
            e = exp_q.pop_front();
            obs = e.sel ? {b_we, b_addr, b_wdata, b_be} : {a_we, a_addr, a_wdata, a_be};
            vectors++;
            if ({a_valid, b_valid} !== {~e.sel, e.sel} || obs !== {e.we, e.addr, e.wdata, e.be}) begin
                miscompares++;
                $display("FAIL sweep_port addr=%h got a=%b b=%b fields=%h want a=%b b=%b fields=%h",
                         e.addr, a_valid, b_valid, obs, ~e.sel, e.sel, {e.we, e.addr, e.wdata, e.be});
            end
            step;
        end
    endtask

    task automatic test_read_b;
        logic [31:0] d;
        a_ready = 1'b1; b_ready = 1'b1;
        accept_req(1'b0, 32'h0000_7F04, 32'h0, 4'hF);
        vectors++;
        if ({a_valid, b_valid, b_we, b_addr} !== {2'b01, 1'b0, 32'h0000_7F04}) begin
            miscompares++;
            $display("FAIL read_b_issue got a=%b b=%b we=%b addr=%h want 0 1 0 00007f04",
                     a_valid, b_valid, b_we, b_addr);
        end
        step;
        vectors++;
        if (req_ready !== 1'b0 || b_valid !== 1'b0 || resp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL read_b_pending got ready=%b b_valid=%b rv=%b want 0 0 0",
                     req_ready, b_valid, resp_valid);
        end
        b_resp_valid = 1'b1; b_rdata = 32'h1234_5678;
        rsp_q.push_back(32'h1234_5678);
        vectors++;
        if (req_ready !== 1'b0 || resp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL read_b_wait got ready=%b rv=%b want 0 0", req_ready, resp_valid);
        end
        step;
        b_resp_valid = 1'b0;
        d = rsp_q.pop_front();
        vectors++;
        if (resp_valid !== 1'b1 || resp_rdata !== d || req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL read_b_return got rv=%b data=%h ready=%b want 1 %h 1",
                     resp_valid, resp_rdata, req_ready, d);
        end
        step;
        vectors++;
        if (resp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL read_b_pulse got rv=%b want 0", resp_valid);
        end
    endtask

    task automatic test_read_a_spurious;
        logic [31:0] d;
        a_ready = 1'b1; b_ready = 1'b1;
        rsp_q.push_back(32'h0000_0042);
        accept_req(1'b0, 32'h0000_0100, 32'h0, 4'hF);
        // response in the acceptance cycle must be ignored
        a_resp_valid = 1'b1; a_rdata = 32'hBAD0_BAD0;
        step;
        a_resp_valid = 1'b0;
        vectors++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL read_a_early got rv=%b ready=%b want 0 0", resp_valid, req_ready);
        end
        b_resp_valid = 1'b1; b_rdata = 32'hBAD0_BAD0;
        step;
        b_resp_valid = 1'b0;
        vectors++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL read_a_wrong_port got rv=%b ready=%b want 0 0", resp_valid, req_ready);
        end
        a_resp_valid = 1'b1; a_rdata = 32'h0000_0042;
        step;
        a_resp_valid = 1'b0;
        d = rsp_q.pop_front();
        vectors++;
        if (resp_valid !== 1'b1 || resp_rdata !== d) begin
            miscompares++;
            $display("FAIL read_a_return got rv=%b data=%h want 1 %h", resp_valid, resp_rdata, d);
        end
    endtask

    task automatic test_backpressure;
        req_t e;
        a_ready = 1'b0; b_ready = 1'b0;
        exp_q.push_back(make_req(1'b1, 32'h0000_0020, 32'h0BAD_CAFE, 4'h3));
        accept_req(1'b1, 32'h0000_0020, 32'h0BAD_CAFE, 4'h3);
        e = exp_q.pop_front();
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if ({a_valid, req_ready, a_we, a_addr, a_wdata, a_be} !== {2'b10, e.we, e.addr, e.wdata, e.be}) begin
                miscompares++;
                $display("FAIL backpressure_hold cyc=%0d got av=%b rdy=%b addr=%h wd=%h be=%h want 1 0 %h %h %h",
                         i, a_valid, req_ready, a_addr, a_wdata, a_be, e.addr, e.wdata, e.be);
            end
            step;
        end
        a_ready = 1'b1;
        step;
        vectors++;
        if (a_valid !== 1'b0 || req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL backpressure_release got av=%b rdy=%b want 0 1", a_valid, req_ready);
        end
    endtask

    task automatic test_back_to_back;
        req_t e;
        int accepts = 0;
        int bad = 0;
        a_ready = 1'b1; b_ready = 1'b1;
        req_valid = 1'b1; req_we = 1'b1; req_wdata = 32'h1111_0000; req_be = 4'hF;
        req_addr = 32'h0000_0200;
        for (int c = 0; c < 8; c++) begin
            if (req_ready === 1'b1) begin
                exp_q.push_back(make_req(1'b1, req_addr, req_wdata, req_be));
                accepts++;
            end
            step;
            if (a_valid === 1'b1) begin
                e = exp_q.pop_front();
                if (a_addr !== e.addr || a_wdata !== e.wdata) bad++;
                req_addr = req_addr + 32'd4;
                req_wdata = req_wdata + 32'd1;
            end
        end
        req_valid = 1'b0;
        vectors++;
        if (accepts != 4 || bad != 0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL back_to_back got accepts=%0d badfields=%0d left=%0d want 4 0 0",
                     accepts, bad, exp_q.size());
        end
        step;
    endtask

    task automatic test_reset_mid;
        a_ready = 1'b0; b_ready = 1'b0;
        accept_req(1'b1, 32'h0000_0300, 32'h5555_AAAA, 4'hF);
        reset = 1'b0;
        step;
        vectors++;
        if ({req_ready, a_valid, b_valid, resp_valid} !== 4'b0000 || a_addr !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_mid_buf got rdy=%b av=%b bv=%b rv=%b addr=%h want 0 0 0 0 0",
                     req_ready, a_valid, b_valid, resp_valid, a_addr);
        end
        reset = 1'b1;
        #1;
        a_ready = 1'b1;
        accept_req(1'b0, 32'h0000_0400, 32'h0, 4'hF);
        step;
        vectors++;
        if (req_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_pending got ready=%b want 0", req_ready);
        end
        reset = 1'b0;
        step;
        vectors++;
        if ({req_ready, a_valid, b_valid, resp_valid} !== 4'b0000 || resp_rdata !== 32'h0 ||
            {a_we, a_addr, a_wdata, a_be} !== 69'h0) begin
            miscompares++;
            $display("FAIL reset_mid_outputs got rdy=%b av=%b bv=%b rv=%b rd=%h want all 0",
                     req_ready, a_valid, b_valid, resp_valid, resp_rdata);
        end
        reset = 1'b1;
        a_resp_valid = 1'b1; a_rdata = 32'h0000_0077;
        step;
        a_resp_valid = 1'b0;
        vectors++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid_late_resp got rv=%b ready=%b want 0 1", resp_valid, req_ready);
        end
    endtask

    initial begin
        reset = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
        a_ready = 1'b0; b_ready = 1'b0;
        a_resp_valid = 1'b0; b_resp_valid = 1'b0;
        a_rdata = '0; b_rdata = '0;
        #2;

        test_reset;
        test_write_a;
        test_addr_sweep;
        test_read_b;
        test_read_a_spurious;
        test_backpressure;
        test_back_to_back;
        test_reset_mid;

        vectors++;
        if (exp_q.size() != 0 || rsp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain got req=%0d rsp=%0d want 0 0", exp_q.size(), rsp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
